// File: rtl/note_key_encoder_if.sv
// rtl/note_key_encoder_if.sv - key input and note output bundle for note_key_encoder
interface note_key_encoder_if;
  logic [7:0] KEYS;
  logic [7:0] KEY_STABLE;
  logic [3:0] NOTE;
  logic       NOTE_STROBE;

  modport master (
    output KEYS,
    input  KEY_STABLE,
    input  NOTE,
    input  NOTE_STROBE
  );

  modport slave (
    input  KEYS,
    output KEY_STABLE,
    output NOTE,
    output NOTE_STROBE
  );
endinterface

// File: rtl/note_key_encoder.sv
// rtl/note_key_encoder.sv - synchronise, debounce and encode piano keys into a note code
// Optional NOTE_CHORD_REJECT_EN: multi-key presses encode as none instead of lowest-index-wins.
module note_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic CLK,
  input  logic RESET_N,
  note_key_encoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1_q, sync1_d;
  logic [7:0]       sync2_q, sync2_d;
  logic [7:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       key_stable_q, key_stable_d;
  logic [3:0]       note_q, note_d;
  logic             strobe_q, strobe_d;
  logic [3:0]       enc;

  // Whole-vector debounce: any bit changing restarts the count.
  always_comb begin
    sync1_d      = bus.KEYS;
    sync2_d      = sync1_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    key_stable_d = key_stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      key_stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Descending scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    enc = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (key_stable_q[i]) enc = 4'(i + 1);
    end
`ifdef NOTE_CHORD_REJECT_EN
    if ((key_stable_q & (key_stable_q - 8'd1)) != 8'd0) enc = 4'd0;
`endif
    note_d   = enc;
    strobe_d = (enc != 4'd0) && (enc != note_q);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      key_stable_q <= '0;
      note_q       <= '0;
      strobe_q     <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      key_stable_q <= key_stable_d;
      note_q       <= note_d;
      strobe_q     <= strobe_d;
    end
  end

  assign bus.KEY_STABLE  = key_stable_q;
  assign bus.NOTE        = note_q;
  assign bus.NOTE_STROBE = strobe_q;

endmodule

// File: tb/tb_note_key_encoder.sv
// tb/tb_note_key_encoder.sv - directed self-checking bench for note_key_encoder (DEBOUNCE_CYCLES=4)
module tb_note_key_encoder;

  logic CLK;
  logic RESET_N;
  int   checks;
  int   fails;
  int   strobe_cnt;
  logic [7:0] ks_or;

  note_key_encoder_if bus ();

  note_key_encoder #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
      if (bus.NOTE_STROBE === 1'b1) strobe_cnt++;
      ks_or = ks_or | bus.KEY_STABLE;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    CLK        = 1'b0;
    RESET_N    = 1'b0;
    checks     = 0;
    fails      = 0;
    strobe_cnt = 0;
    ks_or      = 8'h00;
    bus.KEYS   = 8'h04;

    // 1. reset with a key held
    tick(3);
    chk("reset_key_stable", bus.KEY_STABLE, 8'h00);
    chk("reset_note", {4'h0, bus.NOTE}, 8'h00);
    chk("reset_strobe", {7'h0, bus.NOTE_STROBE}, 8'h00);
    bus.KEYS = 8'h00;
    RESET_N  = 1'b1;
    tick(10);
    chk("idle_note", {4'h0, bus.NOTE}, 8'h00);

    // 2. single press E, edge 0 is the first tick
    strobe_cnt = 0;
    bus.KEYS = 8'h04;
    tick(6);
    chk("press_ks_before_e6", bus.KEY_STABLE, 8'h00);
    tick(1);
    chk("press_ks_e6", bus.KEY_STABLE, 8'h04);
    chk("press_note_e6", {4'h0, bus.NOTE}, 8'h00);
    tick(1);
    chk("press_note_e7", {4'h0, bus.NOTE}, 8'h03);
    chk("press_strobe_e7", {7'h0, bus.NOTE_STROBE}, 8'h01);
    tick(1);
    chk("press_strobe_e8", {7'h0, bus.NOTE_STROBE}, 8'h00);
    chk("press_note_e8", {4'h0, bus.NOTE}, 8'h03);
    chk("press_strobe_count", 8'(strobe_cnt), 8'd1);

    strobe_cnt = 0;
    bus.KEYS = 8'h00;
    tick(7);
    chk("release_note_e6", {4'h0, bus.NOTE}, 8'h03);
    tick(1);
    chk("release_note_e7", {4'h0, bus.NOTE}, 8'h00);
    tick(3);
    chk("release_no_strobe", 8'(strobe_cnt), 8'd0);

    // 3. bounce on F
    strobe_cnt = 0;
    for (int b = 0; b < 5; b++) begin
      bus.KEYS = 8'h08;
      tick(2);
      bus.KEYS = 8'h00;
      tick(2);
    end
    chk("bounce_note_during", {4'h0, bus.NOTE}, 8'h00);
    chk("bounce_ks_during", bus.KEY_STABLE, 8'h00);
    bus.KEYS = 8'h08;
    tick(7);
    chk("bounce_note_e6", {4'h0, bus.NOTE}, 8'h00);
    tick(1);
    chk("bounce_note_e7", {4'h0, bus.NOTE}, 8'h04);
    tick(5);
    chk("bounce_one_strobe", 8'(strobe_cnt), 8'd1);
    bus.KEYS = 8'h00;
    tick(10);
    chk("bounce_release", {4'h0, bus.NOTE}, 8'h00);

    // 4. three-cycle glitch on G
    strobe_cnt = 0;
    ks_or      = 8'h00;
    bus.KEYS = 8'h10;
    tick(3);
    bus.KEYS = 8'h00;
    tick(12);
    chk("glitch_ks_never", ks_or, 8'h00);
    chk("glitch_note", {4'h0, bus.NOTE}, 8'h00);
    chk("glitch_no_strobe", 8'(strobe_cnt), 8'd0);

    // 5. chord, then G, then E->F without release
    strobe_cnt = 0;
    bus.KEYS = 8'h14;
    tick(8);
    chk("chord_ks", bus.KEY_STABLE, 8'h14);
`ifdef NOTE_CHORD_REJECT_EN
    chk("chord_note", {4'h0, bus.NOTE}, 8'h00);
    chk("chord_strobe_count", 8'(strobe_cnt), 8'd0);
`else
    chk("chord_note", {4'h0, bus.NOTE}, 8'h03);
    chk("chord_strobe_count", 8'(strobe_cnt), 8'd1);
`endif
    strobe_cnt = 0;
    bus.KEYS = 8'h10;
    tick(8);
    chk("g_note", {4'h0, bus.NOTE}, 8'h05);
    chk("g_strobe_count", 8'(strobe_cnt), 8'd1);

    strobe_cnt = 0;
    bus.KEYS = 8'h04;
    tick(8);
    chk("e_note", {4'h0, bus.NOTE}, 8'h03);
    chk("e_strobe_count", 8'(strobe_cnt), 8'd1);
    strobe_cnt = 0;
    bus.KEYS = 8'h08;
    tick(8);
    chk("e_to_f_note", {4'h0, bus.NOTE}, 8'h04);
    chk("e_to_f_strobe_count", 8'(strobe_cnt), 8'd1);
    bus.KEYS = 8'h00;
    tick(10);
    chk("pre_reset_idle", {4'h0, bus.NOTE}, 8'h00);

    // 6. reset in the middle of a debounce
    strobe_cnt = 0;
    bus.KEYS = 8'h01;
    tick(3);
    RESET_N = 1'b0;
    tick(1);
    RESET_N = 1'b1;
    chk("midreset_ks", bus.KEY_STABLE, 8'h00);
    chk("midreset_note", {4'h0, bus.NOTE}, 8'h00);
    tick(7);
    chk("midreset_note_e6", {4'h0, bus.NOTE}, 8'h00);
    tick(1);
    chk("midreset_note_e7", {4'h0, bus.NOTE}, 8'h01);
    chk("midreset_strobe_e7", {7'h0, bus.NOTE_STROBE}, 8'h01);
    chk("midreset_strobe_count", 8'(strobe_cnt), 8'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/note_key_encoder.md
Name: note_key_encoder

Overview:
Front-end stage that turns the eight raw piano key inputs into the 4-bit note code consumed by the song-tracking FSMs and the tone generator.
- Synchronises and debounces the key vector.
- Resolves simultaneous presses.
- Registers the resulting note code and pulses a strobe when a new note starts.
- Its NOTE output connects directly to the note input of the song-follower blocks.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles the synchronised key vector must be unchanged before it is accepted (10 ms at 100 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 20: debounce counter width.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RESET_N  input  1  synchronous, active-low reset.
- KEYS  input  8  raw asynchronous key levels, 1 = pressed. Bit mapping: 0=C4, 1=D, 2=E, 3=F, 4=G, 5=A, 6=B, 7=C5.
- KEY_STABLE  output  8  debounced key vector.
- NOTE  output  4  registered note code: none=0, C4=1, D=2, E=3, F=4, G=5, A=6, B=7, C5=8.
- NOTE_STROBE  output  1  one-cycle pulse when NOTE takes a new non-none value.

Behaviour:
- Reset: RESET_N low at a rising edge clears the sync flops, candidate, counter, KEY_STABLE, NOTE (=none) and NOTE_STROBE. Reset has priority over all other activity and aborts any debounce in progress. There is no asynchronous path.
- Synchroniser: two flops, sync1 <= KEYS, sync2 <= sync1.
- Debounce, evaluated each edge on the whole vector:
  - If sync2 != cand: cand <= sync2, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: KEY_STABLE <= cand; cnt holds.
  - Else: cnt <= cnt+1.
- Latency: a KEYS change first sampled at edge 0 and then held appears on KEY_STABLE at edge DEBOUNCE_CYCLES+2, and on NOTE/NOTE_STROBE at edge DEBOUNCE_CYCLES+3.
- Glitch rejection: a change lasting fewer than DEBOUNCE_CYCLES sync2 cycles never reaches KEY_STABLE. A bounce restarts the count from 0.
- Encoder, registered from KEY_STABLE:
  - All zeros -> none.
  - Exactly one bit i set -> code i+1.
  - Several bits set -> the lowest set index wins (default build).
- Strobe: NOTE_STROBE = 1 for exactly one cycle, on the edge where NOTE is loaded with a value that is non-none and differs from its previous value.
  - Covers none->E and E->F.
  - Not asserted for E->none, and not while NOTE stays E.
- Counter: cnt saturates at DEBOUNCE_CYCLES-1 and never wraps. DEBOUNCE_CYCLES=1 accepts any vector stable for one cycle.
- No handshake: downstream samples NOTE every cycle. NOTE holds its value until KEY_STABLE changes.

Optional Feature:
- Macro: NOTE_CHORD_REJECT_EN.
- Defined: when more than one KEY_STABLE bit is set, the encoder outputs none and NOTE_STROBE stays low. A chord therefore behaves as a release for the downstream song FSMs.
- Undefined: lowest-index-wins priority as described above.
- All other behaviour and latencies are identical in both builds.

Test Plan:
Run with DEBOUNCE_CYCLES=4 unless noted.
1. Reset: KEYS=8'h04 held, RESET_N low for 3 edges -> KEY_STABLE=0, NOTE=0, NOTE_STROBE=0. Then release reset.
2. Single press: KEYS 0->8'h04 first sampled at edge 0 -> KEY_STABLE=8'h04 at edge 6; NOTE=3 (E) and NOTE_STROBE=1 at edge 7; NOTE_STROBE=0 at edge 8. Release -> NOTE=0 seven edges after sampling, with no strobe.
3. Bounce: KEYS toggles 8'h08/0 every 2 cycles for 20 cycles, then holds 8'h08 -> NOTE changes only once, to 4 (F), 7 edges after the final toggle; exactly one strobe.
4. Glitch: 3-cycle pulse KEYS=8'h10 -> KEY_STABLE and NOTE remain 0, no strobe.
5. Chord and note change:
   - KEYS=8'h14 -> NOTE=3 (default build) or NOTE=0 with no strobe (NOTE_CHORD_REJECT_EN).
   - Then KEYS=8'h10 -> NOTE=5 (G) with a strobe.
   - Direct E->F without release -> strobe asserted.
6. Mid-debounce reset: KEYS=8'h01 held, RESET_N low at edge 3 for one edge -> counter restarts. NOTE=1 (C4) appears 7 edges after the first post-reset sampling edge, not before.
